// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared types and constants for the slave-side serial link
//
// Contents:
//   HDR_REQ / HDR_RESP : frame header bytes (master->slave / slave->master)
//   rx_state_t         : request frame parser states
//   tx_state_t         : response serializer states
//   status_t           : slave status snapshot, pack_status() builds its byte
package link_pkg;

  localparam logic [7:0] HDR_REQ  = 8'hA5;
  localparam logic [7:0] HDR_RESP = 8'h5A;

  typedef enum logic [1:0] {
    HDR,
    HI,
    LO
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic       liv;
    logic       ok;
    logic       ldr1;
    logic       ldr2;
    logic [2:0] disp;
  } status_t;

  // Status byte layout: {liv, ok, ldr1, ldr2, 0, disp[2:0]}
  function automatic logic [7:0] pack_status(input status_t s);
    return {s.liv, s.ok, s.ldr1, s.ldr2, 1'b0, s.disp};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with mid-bit sampling
//
// Ports:
//   clk, clr   : clock, asynchronous active-low reset
//   rx         : asynchronous serial input, idles high
//   byte_data  : last received byte, valid while byte_valid is high
//   byte_valid : high in the cycle the stop bit samples 1
//   byte_err   : high in the cycle the stop bit samples 0
//   busy       : a byte is being received (start bit seen)
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  logic       rx_meta, rx_sync, rx_prev;
  bit_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q  <= B_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (st_q)
      B_IDLE: begin
        // Edge rather than level, so a line held low after a bad stop bit
        // does not retrigger.
        if (rx_prev && !rx_sync) begin
          st_d  = B_START;
          cnt_d = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_sync ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_sync, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = B_STOP;
          else               bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          st_d       = B_IDLE;
          byte_valid = rx_sync;
          byte_err   = !rx_sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = B_IDLE;
    endcase
  end

  assign byte_data = sh_q;
  assign busy      = (st_q != B_IDLE);

endmodule

// File: rtl/slave_link.sv
// rtl/slave_link.sv - slave end of the Battleship master/slave serial link
//
// Ports:
//   clk, clr                 : clock, asynchronous active-low reset
//   rx, tx                   : serial lines from / to the master (idle high)
//   attack, attack_valid     : last attack vector and its one-cycle update pulse
//   frame_err                : one-cycle pulse on bad stop bit or inter-byte timeout
//   liv, ok, ldr1, ldr2, disp: status reported in the response frame
//   resp_req, resp_busy      : start a response / response in flight
module slave_link
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx,
  output logic        tx,
  output logic [15:0] attack,
  output logic        attack_valid,
  output logic        frame_err,
  input  logic        liv,
  input  logic        ok,
  input  logic        ldr1,
  input  logic        ldr2,
  input  logic [2:0]  disp,
  input  logic        resp_req,
  output logic        resp_busy
);

  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LIMIT);

  // ---------------- receive side ----------------
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, rx_busy;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .byte_data (rx_data),
    .byte_valid(rx_valid),
    .byte_err  (rx_err),
    .busy      (rx_busy)
  );

  rx_state_t     rs_q, rs_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [15:0]   attack_q, attack_d;
  logic          av_q, av_d, fe_q, fe_d;
  logic [GW-1:0] gap_q, gap_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rs_q     <= HDR;
      shadow_q <= '0;
      attack_q <= '0;
      av_q     <= 1'b0;
      fe_q     <= 1'b0;
      gap_q    <= '0;
    end else begin
      rs_q     <= rs_d;
      shadow_q <= shadow_d;
      attack_q <= attack_d;
      av_q     <= av_d;
      fe_q     <= fe_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    rs_d     = rs_q;
    shadow_d = shadow_q;
    attack_d = attack_q;
    av_d     = 1'b0;
    fe_d     = 1'b0;
    gap_d    = gap_q;
    if (rx_err) begin
      fe_d = 1'b1;
      rs_d = HDR;
    end else if (rx_valid) begin
      case (rs_q)
        HDR: if (rx_data == HDR_REQ) rs_d = HI;
        HI: begin
          shadow_d = rx_data;
          rs_d     = LO;
        end
        LO: begin
          attack_d = {shadow_q, rx_data};
          av_d     = 1'b1;
          rs_d     = HDR;
        end
        default: rs_d = HDR;
      endcase
    end else if (rs_q != HDR && gap_q == GAP_LAST) begin
      fe_d = 1'b1;
      rs_d = HDR;
    end
    // Gap timer only runs mid-frame while the line is idle between bytes.
    if (rs_d == HDR || rx_busy || rx_valid) gap_d = '0;
    else if (gap_q != GAP_LAST)              gap_d = gap_q + 1'b1;
  end

  assign attack       = attack_q;
  assign attack_valid = av_q;
  assign frame_err    = fe_q;

  // ---------------- transmit side ----------------
  tx_state_t     ts_q, ts_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    tbit_q, tbit_d;
  logic          tbyte_q, tbyte_d;
  status_t       stat_q, stat_d;
  logic          tx_q, tx_d;
  logic [7:0]    next_byte;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ts_q    <= IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tbyte_q <= 1'b0;
      stat_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      ts_q    <= ts_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tbyte_q <= tbyte_d;
      stat_q  <= stat_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    ts_d    = ts_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tbyte_d = tbyte_q;
    stat_d  = stat_q;
    tx_d    = 1'b1;
    case (ts_q)
      IDLE: begin
        if (resp_req) begin
          ts_d    = START;
          tcnt_d  = '0;
          tbyte_d = 1'b0;
          stat_d  = status_t'{liv, ok, ldr1, ldr2, disp};
        end
      end
      START: begin
        if (tcnt_q == LAST) begin
          ts_d   = DATA;
          tcnt_d = '0;
          tbit_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tcnt_q == LAST) begin
          tcnt_d = '0;
          if (tbit_q == 3'd7) ts_d = STOP;
          else                tbit_d = tbit_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tcnt_q == LAST) begin
          tcnt_d = '0;
          // Status byte follows the header with no idle gap.
          if (!tbyte_q) begin
            ts_d    = START;
            tbyte_d = 1'b1;
          end else begin
            ts_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: ts_d = IDLE;
    endcase
    // Line level is decoded from the next state so tx comes straight off a flop.
    next_byte = tbyte_d ? pack_status(stat_d) : HDR_RESP;
    case (ts_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = next_byte[tbit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign resp_busy = (ts_q != IDLE);

endmodule

// File: tb/tb_slave_link.sv
// tb/tb_slave_link.sv - self-checking bench for slave_link
module tb_slave_link;

  localparam int CPB = 4;
  localparam int GAP = 20;

  logic        clk, clr, rx, tx;
  logic [15:0] attack;
  logic        attack_valid, frame_err;
  logic        liv, ok, ldr1, ldr2;
  logic [2:0]  disp;
  logic        resp_req, resp_busy;

  slave_link #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk(clk), .clr(clr), .rx(rx), .tx(tx),
    .attack(attack), .attack_valid(attack_valid), .frame_err(frame_err),
    .liv(liv), .ok(ok), .ldr1(ldr1), .ldr2(ldr2), .disp(disp),
    .resp_req(resp_req), .resp_busy(resp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed RX activity
  logic [15:0] obs_q[$];
  int          fe_cnt = 0;

  always @(negedge clk) begin
    if (attack_valid === 1'b1) obs_q.push_back(attack);
    if (frame_err === 1'b1) fe_cnt++;
  end

  // Reference model: bytes collected since the last header search, expected
  // attack words, expected frame errors and the current attack register.
  logic [7:0]  pend[$];
  logic [15:0] exp_q[$];
  int          exp_fe = 0;
  logic [15:0] exp_attack = 16'h0000;

  task automatic model_good(input logic [7:0] b);
    pend.push_back(b);
    if (pend[0] != 8'hA5) pend.delete();
    else if (pend.size() == 3) begin
      exp_attack = {pend[1], pend[2]};
      exp_q.push_back(exp_attack);
      pend.delete();
    end
  endtask

  task automatic model_bad();
    exp_fe++;
    pend.delete();
  endtask

  task automatic model_gap();
    if (pend.size() > 0) begin
      exp_fe++;
      pend.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    if (stop_bit) model_good(b);
    else          model_bad();
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  function automatic logic [7:0] rand_not_hdr();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'hA5) v = 8'h3C;
    return v;
  endfunction

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (attack !== 16'h0000) begin n_bad++; $display("FAIL reset_attack: got %h want 0000", attack); end
    n_cmp++; if (attack_valid !== 1'b0) begin n_bad++; $display("FAIL reset_attack_valid: got %b want 0", attack_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (resp_busy !== 1'b0) begin n_bad++; $display("FAIL reset_resp_busy: got %b want 0", resp_busy); end
    clr = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_request();
    logic [15:0] a;
    send_byte(8'hA5, 1'b1); send_byte(8'hE6, 1'b1); send_byte(8'h06, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom);
      send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
      idle_bits($urandom_range(0, 3));
    end
    idle_bits(3);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL request_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL request_attack[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL request_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_resync();
    logic [15:0] a;
    a = 16'($urandom);
    send_byte(8'h3C, 1'b1); send_byte(8'hA5, 1'b1); send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(rand_not_hdr(), 1'b1); send_byte(rand_not_hdr(), 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
    idle_bits(3);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL resync_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL resync_attack[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL resync_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    logic [15:0] a;
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b0);
    idle_bits(2);
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL framing_err_pulse: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (attack !== exp_attack) begin n_bad++; $display("FAIL framing_attack_held: got %h want %h", attack, exp_attack); end
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    a = 16'($urandom);
    send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1); send_byte(8'($urandom), 1'b0);
    idle_bits(3);
    send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
    idle_bits(3);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL framing_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL framing_attack[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL framing_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gap();
    logic [15:0] a;
    send_byte(8'hA5, 1'b1); send_byte(8'hC0, 1'b1);
    idle_bits(25); model_gap();
    send_byte(8'h06, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle_bits(GAP + 3); model_gap();
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL gap_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL gap_no_valid: got %0d want 0", obs_q.size()); end
    a = 16'($urandom);
    send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1);
    idle_bits(GAP - 4);
    send_byte(a[7:0], 1'b1);
    idle_bits(3);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gap_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gap_attack[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL gap_frame_err_after: got %0d want %0d", fe_cnt, exp_fe); end
    obs_q.delete(); exp_q.delete();
  endtask

  // Caller raises resp_req on a negedge; this task samples the 80 following
  // cycles bit by bit, optionally re-requesting at clock 40.
  task automatic check_frame(input logic [7:0] sb, input bit poke, input string tag);
    logic [7:0] b;
    logic [3:0] got;
    logic       e;
    int         busy_hi, pos;
    busy_hi = 0;
    for (int j = 0; j < 20; j++) begin
      b   = (j < 10) ? 8'h5A : sb;
      pos = j % 10;
      e   = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos-1];
      for (int s = 0; s < CPB; s++) begin
        @(negedge clk);
        got[s] = tx;
        if (resp_busy === 1'b1) busy_hi++;
        resp_req = (poke && (j * CPB + s == 39)) ? 1'b1 : 1'b0;
        if (j * CPB + s == 0 || j * CPB + s == 39)
          {liv, ok, ldr1, ldr2, disp} = 7'($urandom);
      end
      n_cmp++; if (got !== {4{e}}) begin n_bad++; $display("FAIL %s_bit%0d: got %b want %b", tag, j, got, {4{e}}); end
    end
    n_cmp++; if (busy_hi != 20 * CPB) begin n_bad++; $display("FAIL %s_busy_len: got %0d want %0d", tag, busy_hi, 20 * CPB); end
    @(negedge clk);
    n_cmp++; if (resp_busy !== 1'b0 || tx !== 1'b1) begin n_bad++; $display("FAIL %s_end: got busy=%b tx=%b want busy=0 tx=1", tag, resp_busy, tx); end
  endtask

  task automatic test_response();
    {liv, ok, ldr1, ldr2, disp} = {1'b1, 1'b1, 1'b0, 1'b1, 3'b101};
    resp_req = 1'b1;
    check_frame(8'hD5, 1'b1, "resp_fixed");
    for (int k = 0; k < 2; k++) begin
      logic [6:0] r;
      idle_bits(1);
      r = 7'($urandom);
      {liv, ok, ldr1, ldr2, disp} = r;
      resp_req = 1'b1;
      check_frame({r[6:3], 1'b0, r[2:0]}, 1'b1, "resp_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] r1, r2;
    r1 = 7'($urandom);
    {liv, ok, ldr1, ldr2, disp} = r1;
    @(negedge clk);
    resp_req = 1'b1;
    check_frame({r1[6:3], 1'b0, r1[2:0]}, 1'b0, "b2b_first");
    // Same negedge where busy was just seen low: request must be taken.
    r2 = 7'($urandom);
    {liv, ok, ldr1, ldr2, disp} = r2;
    resp_req = 1'b1;
    check_frame({r2[6:3], 1'b0, r2[2:0]}, 1'b0, "b2b_second");
  endtask

  task automatic test_mid_reset();
    logic [15:0] a;
    {liv, ok, ldr1, ldr2, disp} = 7'($urandom);
    resp_req = 1'b1;
    @(negedge clk);
    resp_req = 1'b0;
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (resp_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", resp_busy); end
    clr = 1'b0;
    pend.delete(); exp_attack = 16'h0000;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx: got %b want 1", tx); end
    n_cmp++; if (attack !== exp_attack) begin n_bad++; $display("FAIL midrst_attack: got %h want %h", attack, exp_attack); end
    n_cmp++; if (attack_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_pulses: got av=%b fe=%b want 0 0", attack_valid, frame_err); end
    n_cmp++; if (resp_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", resp_busy); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    idle_bits(2);
    send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    a = 16'($urandom);
    send_byte(8'hA5, 1'b1); send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
    idle_bits(3);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_attack[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fe_cnt != exp_fe) begin n_bad++; $display("FAIL midrst_frame_err: got %0d want %0d", fe_cnt, exp_fe); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    clr = 1'b0; rx = 1'b1; resp_req = 1'b0;
    {liv, ok, ldr1, ldr2, disp} = '0;
    test_reset();
    test_request();
    test_resync();
    test_framing();
    test_gap();
    test_response();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
